i2c_master_tx: RTL and testbench



---
 rtl/myfilter_pkg.sv | 18 +
 rtl/i2c_qtick_gen.sv | 45 ++++
 rtl/i2c_master_tx.sv | 189 ++++++++++++++++++
 tb/tb_i2c_master_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myfilter_pkg.sv
// Shared types and constants for the filter's host-side I2C write path.
package myfilter_pkg;

    typedef enum logic [2:0] {
        MIDLE,
        MSTART,
        MADDR,
        MADDR_ACK,
        MLOAD,
        MDATA,
        MDATA_ACK,
        MSTOP
    } i2c_master_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam int unsigned I2C_BYTE_W = 8;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-bit timebase: prescaler pulses qtick every DIV cycles and steps a 2-bit phase.
module i2c_qtick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_in,
    output logic       qtick_out,
    output logic [1:0] q_out
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    q_q, q_d;

    assign qtick_out = en_in && (cnt_q == CW'(DIV - 1));
    assign q_out     = q_q;

    // Disabled means parked at phase 0 so the next enable starts a fresh q0.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (!en_in) begin
            cnt_d = '0;
            q_d   = '0;
        end else if (qtick_out) begin
            cnt_d = '0;
            q_d   = q_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            q_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C initiator: START, address+W, streamed data bytes with ACK checks, STOP.
module i2c_master_tx
    import myfilter_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go_in,
    input  logic [6:0] addr_in,
    input  logic [7:0] data_in,
    input  logic       dvalid_in,
    input  logic       dlast_in,
    output logic       dready_out,
    input  logic       sda_in,
    output logic       scl_oe_out,
    output logic       sda_oe_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       nack_out
);

    localparam logic [2:0] BIT_MSB = 3'(I2C_BYTE_W - 1);

    i2c_master_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        last_q, last_d;
    logic        flag_q, flag_d;
    logic        ack_q, ack_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;

    logic        qtick;
    logic [1:0]  q;
    logic        q_en;
    logic        q_end;
    logic        q_samp;

    // The timebase runs only while a bit or START/STOP is actively being clocked.
    assign q_en   = (state_q != MIDLE) && (state_q != MLOAD);
    assign q_end  = qtick && (q == 2'd3);
    assign q_samp = qtick && (q == 2'd2);

    i2c_qtick_gen #(
        .DIV (DIV)
    ) u_qtick (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_in     (q_en),
        .qtick_out (qtick),
        .q_out     (q)
    );

    assign dready_out = (state_q == MLOAD) && dvalid_in;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        flag_d   = flag_q;
        ack_d    = ack_q;
        done_d   = 1'b0;
        nack_d   = 1'b0;

        case (state_q)
            MIDLE: begin
                if (go_in) begin
                    shift_d  = {addr_in, I2C_RW_WRITE};
                    bitcnt_d = BIT_MSB;
                    state_d  = MSTART;
                end
            end
            MSTART: begin
                if (q_end) state_d = MADDR;
            end
            MADDR, MDATA: begin
                if (q_end) begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q - 3'd1;
                    if (bitcnt_q == 3'd0)
                        state_d = (state_q == MADDR) ? MADDR_ACK : MDATA_ACK;
                end
            end
            MADDR_ACK, MDATA_ACK: begin
                if (q_samp) ack_d = sda_in;
                if (q_end) begin
                    if (ack_q) begin
                        flag_d  = 1'b1;
                        state_d = MSTOP;
                    end else if ((state_q == MDATA_ACK) && last_q) begin
                        state_d = MSTOP;
                    end else begin
                        state_d = MLOAD;
                    end
                end
            end
            MLOAD: begin
                if (dvalid_in) begin
                    shift_d  = data_in;
                    last_d   = dlast_in;
                    bitcnt_d = BIT_MSB;
                    state_d  = MDATA;
                end
            end
            MSTOP: begin
                if (q_end) begin
                    state_d = MIDLE;
                    done_d  = 1'b1;
                    nack_d  = flag_q;
                    flag_d  = 1'b0;
                end
            end
            default: state_d = MIDLE;
        endcase
    end

    // Line drive for the current state/phase; LOAD parks SCL low and leaves SDA alone.
    always_comb begin
        scl_d  = 1'b0;
        sda_d  = 1'b0;
        busy_d = (state_d != MIDLE);
        case (state_q)
            MSTART: begin
                scl_d = 1'b0;
                sda_d = q[1];
            end
            MADDR, MDATA: begin
                scl_d = ~q[1];
                sda_d = ~shift_q[7];
            end
            MADDR_ACK, MDATA_ACK: begin
                scl_d = ~q[1];
                sda_d = 1'b0;
            end
            MLOAD: begin
                scl_d = 1'b1;
                sda_d = sda_q;
            end
            MSTOP: begin
                scl_d = (q == 2'd0);
                sda_d = ~q[1];
            end
            default: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MIDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            last_q   <= 1'b0;
            flag_q   <= 1'b0;
            ack_q    <= 1'b0;
            scl_q    <= 1'b0;
            sda_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            flag_q   <= flag_d;
            ack_q    <= ack_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
        end
    end

    assign scl_oe_out = scl_q;
    assign sda_oe_out = sda_q;
    assign busy_out   = busy_q;
    assign done_out   = done_q;
    assign nack_out   = nack_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Directed bench for i2c_master_tx with a bus monitor and a simple ACKing target model.
module tb_i2c_master_tx;

    localparam int unsigned DIV = 4;
    localparam int          LIM = 3000;

    logic       clk;
    logic       rst_n;
    logic       go_in;
    logic [6:0] addr_in;
    logic [7:0] data_in;
    logic       dvalid_in;
    logic       dlast_in;
    logic       dready_out;
    logic       scl_oe_out;
    logic       sda_oe_out;
    logic       busy_out;
    logic       done_out;
    logic       nack_out;
    logic       resp_pull;
    wire        sda_line = ~(sda_oe_out | resp_pull);

    i2c_master_tx #(
        .DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go_in      (go_in),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .dvalid_in  (dvalid_in),
        .dlast_in   (dlast_in),
        .dready_out (dready_out),
        .sda_in     (sda_line),
        .scl_oe_out (scl_oe_out),
        .sda_oe_out (sda_oe_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .nack_out   (nack_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        int          nb;
        logic [23:0] data;
        logic [3:0]  nack_mask;
        int          gap;
        bit          go_again;
        int          exp_cycles;
        int          exp_hs;
        bit          exp_nack;
        int          exp_maxlow;
    } vec_t;

    vec_t vecs[5];

    int n_checks = 0;
    int n_errors = 0;

    // Bus monitor / target model state
    bit          mon_en = 1'b0;
    logic [3:0]  nack_mask = 4'b0;
    logic        mon_prev_scl;
    logic        mon_prev_sda;
    logic [63:0] mon_bits;
    int          mon_nbits, mon_start, mon_stop, mon_falls, mon_hs, mon_run, mon_maxlow;
    int          slot;
    bit          done_seen;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_prev_scl = scl_oe_out;
        mon_prev_sda = sda_line;
        mon_bits     = '0;
        mon_nbits    = 0;
        mon_start    = 0;
        mon_stop     = 0;
        mon_falls    = 0;
        mon_hs       = 0;
        mon_run      = 0;
        mon_maxlow   = 0;
        resp_pull    = 1'b0;
    endtask

    // Target ACKs slot n (0 = address) between SCL falls 9+9n and 10+9n unless masked.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((sda_line !== mon_prev_sda) && !scl_oe_out) begin
                if (!sda_line) mon_start++;
                else           mon_stop++;
            end
            if (!scl_oe_out && mon_prev_scl) begin
                mon_bits = {mon_bits[62:0], sda_line};
                mon_nbits++;
            end
            if (scl_oe_out && !mon_prev_scl) begin
                mon_falls++;
                slot = mon_falls / 9 - 1;
                resp_pull = ((mon_falls % 9) == 0) && (slot >= 0) && (slot < 4) && !nack_mask[slot];
            end
            if (dvalid_in && dready_out) mon_hs++;
            if (scl_oe_out) begin
                mon_run++;
                if (mon_run > mon_maxlow) mon_maxlow = mon_run;
            end else begin
                mon_run = 0;
            end
            mon_prev_scl = scl_oe_out;
            mon_prev_sda = sda_line;
        end
    end

    task automatic run_vec(input int vi, input vec_t v);
        int          t;
        int          first_fall;
        int          n_sent;
        logic        nack_at_done;
        logic [63:0] ebits;
        int          en;
        string       p;
        logic [7:0]  b8;

        p = $sformatf("v%0d_", vi);
        ebits = '0;
        en = 0;
        for (int i = 6; i >= 0; i--) begin
            ebits = {ebits[62:0], v.addr[i]};
            en++;
        end
        ebits = {ebits[62:0], 1'b0};
        ebits = {ebits[62:0], v.nack_mask[0]};
        en += 2;
        n_sent = 0;
        if (!v.nack_mask[0]) begin
            for (int b = 0; b < v.nb; b++) begin
                b8 = v.data[23 - 8*b -: 8];
                for (int i = 7; i >= 0; i--) begin
                    ebits = {ebits[62:0], b8[i]};
                    en++;
                end
                ebits = {ebits[62:0], v.nack_mask[b+1]};
                en++;
                n_sent++;
                if (v.nack_mask[b+1]) break;
            end
        end
        ebits = {ebits[62:0], 1'b0};
        en++;

        @(posedge clk); #1;
        clear_mon();
        nack_mask = v.nack_mask;
        mon_en    = 1'b1;
        done_seen = 1'b0;
        go_in     = 1'b1;
        addr_in   = v.addr;
        @(posedge clk); #1;
        go_in     = 1'b0;
        addr_in   = 7'h7F;
        t          = 0;
        first_fall = 0;
        nack_at_done = 1'b0;

        fork
            begin
                for (int b = 0; b < v.nb; b++) begin
                    bit got;
                    got = 1'b0;
                    if (b == 1 && v.gap > 0) begin
                        repeat (v.gap) @(posedge clk);
                        #1;
                    end
                    data_in   = v.data[23 - 8*b -: 8];
                    dlast_in  = (b == v.nb - 1);
                    dvalid_in = 1'b1;
                    for (int k = 0; k < LIM && !done_seen; k++) begin
                        @(negedge clk);
                        if (dready_out) begin
                            got = 1'b1;
                            break;
                        end
                    end
                    if (!got) break;
                    @(posedge clk); #1;
                    dvalid_in = 1'b0;
                end
                dvalid_in = 1'b0;
                dlast_in  = 1'b0;
            end
            begin
                while (t < LIM) begin
                    @(posedge clk);
                    t++;
                    #1;
                    if (v.go_again && t == 100) begin
                        go_in   = 1'b1;
                        addr_in = 7'h11;
                    end else begin
                        go_in = 1'b0;
                    end
                    if (first_fall == 0 && scl_oe_out) first_fall = t;
                    if (done_out) begin
                        nack_at_done = nack_out;
                        break;
                    end
                end
                done_seen = 1'b1;
            end
        join
        mon_en = 1'b0;

        check({p, "go_to_done_cycles"}, t, v.exp_cycles);
        check({p, "nack_with_done"}, nack_at_done, v.exp_nack);
        check({p, "first_scl_fall"}, first_fall, 4*DIV + 1);
        check({p, "busy_at_done"}, busy_out, 0);
        @(posedge clk); #1;
        check({p, "done_nack_one_cycle"}, {done_out, nack_out}, 0);
        check({p, "handshakes"}, mon_hs, v.exp_hs);
        check({p, "bits_on_scl_rise_count"}, mon_nbits, en);
        check({p, "bits_on_scl_rise"}, mon_bits, ebits);
        check({p, "start_edges"}, mon_start, 1);
        check({p, "stop_edges"}, mon_stop, 1);
        check({p, "max_scl_low_run"}, mon_maxlow, v.exp_maxlow);
        if (v.exp_hs != n_sent) begin
            n_errors++;
            $display("FAIL %s table_vs_model_bytes: got %0d expected %0d", p, n_sent, v.exp_hs);
        end
    endtask

    initial begin
        bit quiet_ok;
        rst_n     = 1'b0;
        go_in     = 1'b0;
        addr_in   = '0;
        data_in   = '0;
        dvalid_in = 1'b1;
        dlast_in  = 1'b0;
        resp_pull = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {scl_oe_out, sda_oe_out, busy_out, done_out, nack_out, dready_out}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_dvalid_ignored", dready_out, 0);
        dvalid_in = 1'b0;

        //          addr   nb  data                  nackm    gap  again cyc  hs nack maxlow
        vecs[0] = '{7'h2A, 1, {8'hA5, 16'h0000},     4'b0000, 0,   0,    321, 1, 0,   9};
        vecs[1] = '{7'h2A, 1, {8'hA5, 16'h0000},     4'b0001, 0,   0,    176, 0, 1,   8};
        vecs[2] = '{7'h55, 3, {8'h01, 8'h80, 8'hFF}, 4'b0000, 194, 0,    661, 3, 0,   59};
        vecs[3] = '{7'h13, 3, {8'hC3, 8'h3C, 8'h77}, 4'b0100, 0,   0,    466, 2, 1,   9};
        vecs[4] = '{7'h3C, 1, {8'h5A, 16'h0000},     4'b0000, 0,   1,    321, 1, 0,   9};

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a data byte: lines drop immediately, no STOP.
        @(posedge clk); #1;
        clear_mon();
        nack_mask = 4'b0000;
        mon_en    = 1'b1;
        data_in   = 8'hA5;
        dlast_in  = 1'b1;
        dvalid_in = 1'b1;
        go_in     = 1'b1;
        addr_in   = 7'h2A;
        @(posedge clk); #1;
        go_in = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("rst_busy_before", busy_out, 1);
        check("rst_handshake_before", mon_hs, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_lines", {scl_oe_out, sda_oe_out}, 0);
        check("rst_async_busy", busy_out, 0);
        mon_en    = 1'b0;
        resp_pull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dready_held", dready_out, 0);
        rst_n = 1'b1;
        quiet_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (scl_oe_out || sda_oe_out || busy_out || done_out || nack_out || dready_out) quiet_ok = 1'b0;
        end
        check("post_rst_quiet", quiet_ok, 1);
        dvalid_in = 1'b0;
        dlast_in  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
